mul_rs_dispatch: RTL and testbench

Reservation station and dispatch controller for the multiply/divide execution unit of the Tomasulo core. It accepts renamed mul/div instructions from the issue stage into a 3-entry station. It captures pending operands by snooping the common data bus (CDB), and dispatches the oldest operand-ready entry to the single non-pipelined mul/div unit over the `ex_b` start interface. Each entry is held until the unit reports completion for that entry.

---
 rtl/tomasulo_pkg.sv | 36 +++
 rtl/rs_age_select.sv | 29 ++
 rtl/mul_rs_dispatch.sv | 198 +++++++++++++++++++
 tb/tb_mul_rs_dispatch.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared constants, entry type and helpers for the Tomasulo core
package tomasulo_pkg;

    localparam int ROB_W    = 3;
    localparam int RS_IDX_W = 3;
    localparam int DW       = 8;
    localparam int FUNC_W   = 4;
    localparam int RD_W     = 4;

    localparam logic [FUNC_W-1:0] FUNC_MUL = 4'b0010;
    localparam logic [FUNC_W-1:0] FUNC_DIV = 4'b0011;

    localparam logic [1:0] AGE_MAX = 2'd2;

    // One reservation-station slot; q set means the operand still waits on tag
    typedef struct packed {
        logic              valid;
        logic              inflight;
        logic [1:0]        age;
        logic [FUNC_W-1:0] func;
        logic [RD_W-1:0]   rd;
        logic [ROB_W-1:0]  rob;
        logic              q1;
        logic [ROB_W-1:0]  t1;
        logic [DW-1:0]     d1;
        logic              q2;
        logic [ROB_W-1:0]  t2;
        logic [DW-1:0]     d2;
    } rs_entry_t;

    // Age grows by one per younger issue and saturates at the oldest value
    function automatic logic [1:0] age_bump(input logic [1:0] age);
        return (age >= AGE_MAX) ? AGE_MAX : age + 2'd1;
    endfunction

endpackage

// File: rtl/rs_age_select.sv
// rtl/rs_age_select.sv - picks the oldest ready reservation-station entry
module rs_age_select
    import tomasulo_pkg::*;
#(
    parameter int ENTRIES = 3
) (
    input  logic [ENTRIES-1:0]   ready,
    input  logic [2*ENTRIES-1:0] ages,
    output logic                 sel_valid,
    output logic [RS_IDX_W-1:0]  sel_idx
);

    logic [1:0] best_age;

    // Strictly-greater compare so a saturated tie resolves to the lowest index
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        best_age  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (ready[i] && (!sel_valid || ages[2*i +: 2] > best_age)) begin
                sel_valid = 1'b1;
                sel_idx   = RS_IDX_W'(i);
                best_age  = ages[2*i +: 2];
            end
        end
    end

endmodule

// File: rtl/mul_rs_dispatch.sv
// rtl/mul_rs_dispatch.sv - mul/div reservation station with oldest-ready dispatch
module mul_rs_dispatch
    import tomasulo_pkg::*;
#(
    parameter int ENTRIES = 3,
    parameter int DW      = 8
) (
    input  logic                clk1,
    input  logic                rst,
    input  logic                flush,
    input  logic                iss_valid,
    output logic                iss_ready,
    input  logic [3:0]          iss_func,
    input  logic [3:0]          iss_rd,
    input  logic [2:0]          iss_rob,
    input  logic                iss_q1,
    input  logic                iss_q2,
    input  logic [2:0]          iss_t1,
    input  logic [2:0]          iss_t2,
    input  logic [DW-1:0]       iss_d1,
    input  logic [DW-1:0]       iss_d2,
    input  logic                cdb_valid,
    input  logic [2:0]          cdb_rob,
    input  logic [15:0]         cdb_data,
    output logic                ex_b,
    output logic [2:0]          rs_index,
    output logic [2:0]          rob_ind,
    output logic [3:0]          func,
    output logic [3:0]          rd,
    output logic [DW-1:0]       rs1_data,
    output logic [DW-1:0]       rs2_data,
    input  logic                ex_done,
    input  logic [2:0]          ex_done_idx,
    output logic [1:0]          mulcount,
    output logic                busy
);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t                state;
    rs_entry_t             ent   [ENTRIES];
    rs_entry_t             ent_n [ENTRIES];
    logic [ENTRIES-1:0]    cand;
    logic [2*ENTRIES-1:0]  ages;
    logic                  sel_valid;
    logic [RS_IDX_W-1:0]   sel_idx;
    logic                  free_found;
    logic [RS_IDX_W-1:0]   free_idx;
    logic                  issue_fire;
    logic                  dispatch_fire;
    logic                  done_fire;
    logic                  byp1;
    logic                  byp2;
    logic [1:0]            mulcount_n;
    logic                  unused_cdb_hi;

    // Only the low byte of a broadcast is an operand for this unit
    assign unused_cdb_hi = ^cdb_data[15:8];

    // Candidate mask, age vector and lowest free slot from registered state
    always_comb begin
        cand       = '0;
        ages       = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            cand[i]        = ent[i].valid & ~ent[i].inflight & ~ent[i].q1 & ~ent[i].q2;
            ages[2*i +: 2] = ent[i].age;
            if (!ent[i].valid) begin
                free_found = 1'b1;
                free_idx   = RS_IDX_W'(i);
            end
        end
    end

    rs_age_select #(.ENTRIES(ENTRIES)) u_age_select (
        .ready     (cand),
        .ages      (ages),
        .sel_valid (sel_valid),
        .sel_idx   (sel_idx)
    );

    assign issue_fire    = iss_valid & iss_ready & free_found;
    assign dispatch_fire = (state == ST_IDLE) & sel_valid;
    assign done_fire     = (state == ST_BUSY) & ex_done & (ex_done_idx == rs_index);
    assign byp1          = iss_q1 & cdb_valid & (iss_t1 == cdb_rob);
    assign byp2          = iss_q2 & cdb_valid & (iss_t2 == cdb_rob);
    assign mulcount_n    = mulcount + {1'b0, issue_fire} - {1'b0, done_fire};

    // Next entry state: wakeup, ageing, dispatch mark, completion and issue write
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            ent_n[i] = ent[i];
            if (ent[i].valid && cdb_valid && ent[i].q1 && ent[i].t1 == cdb_rob) begin
                ent_n[i].q1 = 1'b0;
                ent_n[i].d1 = cdb_data[7:0];
            end
            if (ent[i].valid && cdb_valid && ent[i].q2 && ent[i].t2 == cdb_rob) begin
                ent_n[i].q2 = 1'b0;
                ent_n[i].d2 = cdb_data[7:0];
            end
            if (issue_fire && ent[i].valid) begin
                ent_n[i].age = age_bump(ent[i].age);
            end
            if (dispatch_fire && sel_idx == RS_IDX_W'(i)) begin
                ent_n[i].inflight = 1'b1;
            end
            if (done_fire && rs_index == RS_IDX_W'(i)) begin
                ent_n[i] = '0;
            end
            if (issue_fire && free_idx == RS_IDX_W'(i)) begin
                ent_n[i].valid    = 1'b1;
                ent_n[i].inflight = 1'b0;
                ent_n[i].age      = 2'd0;
                ent_n[i].func     = iss_func;
                ent_n[i].rd       = iss_rd;
                ent_n[i].rob      = iss_rob;
                ent_n[i].q1       = iss_q1 & ~byp1;
                ent_n[i].t1       = iss_t1;
                ent_n[i].d1       = byp1 ? cdb_data[7:0] : iss_d1;
                ent_n[i].q2       = iss_q2 & ~byp2;
                ent_n[i].t2       = iss_t2;
                ent_n[i].d2       = byp2 ? cdb_data[7:0] : iss_d2;
            end
        end
    end

    // Entry storage; reset and flush both empty the station
    always_ff @(posedge clk1) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (rst || flush) begin
                ent[i] <= '0;
            end else begin
                ent[i] <= ent_n[i];
            end
        end
    end

    // Occupancy count and the registered free-slot indication derived from it
    always_ff @(posedge clk1) begin
        if (rst || flush) begin
            mulcount  <= 2'd0;
            iss_ready <= 1'b1;
        end else begin
            mulcount  <= mulcount_n;
            iss_ready <= (mulcount_n != 2'd3);
        end
    end

    // Dispatch FSM: launch the oldest ready entry, then wait for its completion
    always_ff @(posedge clk1) begin
        if (rst || flush) begin
            state    <= ST_IDLE;
            ex_b     <= 1'b0;
            busy     <= 1'b0;
            rs_index <= '0;
            rob_ind  <= '0;
            func     <= '0;
            rd       <= '0;
            rs1_data <= '0;
            rs2_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ex_b <= 1'b0;
                    if (sel_valid) begin
                        for (int i = 0; i < ENTRIES; i++) begin
                            if (sel_idx == RS_IDX_W'(i)) begin
                                rob_ind  <= ent[i].rob;
                                func     <= ent[i].func;
                                rd       <= ent[i].rd;
                                rs1_data <= ent[i].d1;
                                rs2_data <= ent[i].d2;
                            end
                        end
                        rs_index <= sel_idx;
                        ex_b     <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    ex_b <= 1'b0;
                    if (done_fire) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    ex_b  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_rs_dispatch.sv
// tb/tb_mul_rs_dispatch.sv - scoreboard bench for the mul/div reservation station
module tb_mul_rs_dispatch;
    import tomasulo_pkg::*;

    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        iss_valid = 1'b0;
    logic        iss_ready;
    logic [3:0]  iss_func = '0;
    logic [3:0]  iss_rd = '0;
    logic [2:0]  iss_rob = '0;
    logic        iss_q1 = 1'b0;
    logic        iss_q2 = 1'b0;
    logic [2:0]  iss_t1 = '0;
    logic [2:0]  iss_t2 = '0;
    logic [7:0]  iss_d1 = '0;
    logic [7:0]  iss_d2 = '0;
    logic        cdb_valid = 1'b0;
    logic [2:0]  cdb_rob = '0;
    logic [15:0] cdb_data = '0;
    logic        ex_b;
    logic [2:0]  rs_index;
    logic [2:0]  rob_ind;
    logic [3:0]  func;
    logic [3:0]  rd;
    logic [7:0]  rs1_data;
    logic [7:0]  rs2_data;
    logic        ex_done = 1'b0;
    logic [2:0]  ex_done_idx = '0;
    logic [1:0]  mulcount;
    logic        busy;

    typedef struct packed {
        logic [2:0] idx;
        logic [2:0] rob;
        logic [3:0] fn;
        logic [3:0] rd;
        logic [7:0] d1;
        logic [7:0] d2;
    } disp_t;

    disp_t      exp_q[$];
    disp_t      mon_got;
    disp_t      mon_want;
    int         n_checks = 0;
    int         n_pass = 0;
    logic       prev_exb = 1'b0;
    logic [4:0] st;

    mul_rs_dispatch #(.ENTRIES(3), .DW(8)) dut (
        .clk1        (clk1),
        .rst         (rst),
        .flush       (flush),
        .iss_valid   (iss_valid),
        .iss_ready   (iss_ready),
        .iss_func    (iss_func),
        .iss_rd      (iss_rd),
        .iss_rob     (iss_rob),
        .iss_q1      (iss_q1),
        .iss_q2      (iss_q2),
        .iss_t1      (iss_t1),
        .iss_t2      (iss_t2),
        .iss_d1      (iss_d1),
        .iss_d2      (iss_d2),
        .cdb_valid   (cdb_valid),
        .cdb_rob     (cdb_rob),
        .cdb_data    (cdb_data),
        .ex_b        (ex_b),
        .rs_index    (rs_index),
        .rob_ind     (rob_ind),
        .func        (func),
        .rd          (rd),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .ex_done     (ex_done),
        .ex_done_idx (ex_done_idx),
        .mulcount    (mulcount),
        .busy        (busy)
    );

    always #5 clk1 = ~clk1;

    // {ex_b, busy, iss_ready, mulcount}
    assign st = {ex_b, busy, iss_ready, mulcount};

    // Scoreboard: every dispatch strobe must match the next expected op
    always @(negedge clk1) begin
        if (!rst) begin
            if (ex_b) begin
                mon_got = {rs_index, rob_ind, func, rd, rs1_data, rs2_data};
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL dispatch_unexpected: got %h, required no dispatch", mon_got);
                end else begin
                    mon_want = exp_q.pop_front();
                    if (mon_got !== mon_want)
                        $display("FAIL dispatch_fields: got %h, required %h", mon_got, mon_want);
                    else
                        n_pass++;
                end
                n_checks++;
                if (prev_exb !== 1'b0)
                    $display("FAIL ex_b_pulse: got two-cycle strobe, required one cycle");
                else
                    n_pass++;
            end
            prev_exb = ex_b;
        end
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic issue(input logic [3:0] f, input logic [3:0] d, input logic [2:0] rb,
                         input logic q1, input logic [2:0] t1, input logic [7:0] v1,
                         input logic q2, input logic [2:0] t2, input logic [7:0] v2);
        iss_func = f; iss_rd = d; iss_rob = rb;
        iss_q1 = q1; iss_t1 = t1; iss_d1 = v1;
        iss_q2 = q2; iss_t2 = t2; iss_d2 = v2;
        iss_valid = 1'b1;
        tick();
        iss_valid = 1'b0;
    endtask

    task automatic complete(input logic [2:0] idx);
        ex_done = 1'b1;
        ex_done_idx = idx;
        tick();
        ex_done = 1'b0;
    endtask

    task automatic broadcast(input logic [2:0] tag, input logic [15:0] data);
        cdb_valid = 1'b1;
        cdb_rob = tag;
        cdb_data = data;
        tick();
        cdb_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if (st !== 5'b0_0_1_00) $display("FAIL reset_status: got %b, required 00100", st);
        else n_pass++;
        n_checks++;
        if ({rs_index, rob_ind, func, rd, rs1_data, rs2_data} !== 30'd0)
            $display("FAIL reset_fields: got %h, required 0", {rs_index, rob_ind, func, rd, rs1_data, rs2_data});
        else n_pass++;
    endtask

    task automatic test_ready_dispatch();
        exp_q.push_back({3'd0, 3'd2, FUNC_MUL, 4'd4, 8'd5, 8'd7});
        issue(FUNC_MUL, 4'd4, 3'd2, 1'b0, 3'd0, 8'd5, 1'b0, 3'd0, 8'd7);
        n_checks++;
        if (st !== 5'b0_0_1_01) $display("FAIL t1_residency: got %b, required 00101", st);
        else n_pass++;
        tick();
        n_checks++;
        if (st !== 5'b1_1_1_01) $display("FAIL t1_dispatch: got %b, required 11101", st);
        else n_pass++;
        tick();
        n_checks++;
        if (st !== 5'b0_1_1_01) $display("FAIL t1_strobe_drop: got %b, required 01101", st);
        else n_pass++;
        complete(3'd0);
        n_checks++;
        if (st !== 5'b0_0_1_00) $display("FAIL t1_complete: got %b, required 00100", st);
        else n_pass++;
    endtask

    task automatic test_cdb_wakeup();
        exp_q.push_back({3'd0, 3'd1, FUNC_MUL, 4'd1, 8'h09, 8'h04});
        issue(FUNC_MUL, 4'd1, 3'd1, 1'b1, 3'd3, 8'hAA, 1'b0, 3'd0, 8'h04);
        broadcast(3'd2, 16'h0077);
        tick();
        n_checks++;
        if (st !== 5'b0_0_1_01) $display("FAIL t2_wait: got %b, required 00101", st);
        else n_pass++;
        broadcast(3'd3, 16'h0109);
        n_checks++;
        if (st !== 5'b0_0_1_01) $display("FAIL t2_wake_edge: got %b, required 00101", st);
        else n_pass++;
        tick();
        n_checks++;
        if ({st, rs1_data} !== {5'b1_1_1_01, 8'h09})
            $display("FAIL t2_dispatch: got %b/%h, required 11101/09", st, rs1_data);
        else n_pass++;
        complete(3'd0);
        n_checks++;
        if (st !== 5'b0_0_1_00) $display("FAIL t2_complete: got %b, required 00100", st);
        else n_pass++;
    endtask

    task automatic test_bypass();
        exp_q.push_back({3'd0, 3'd5, FUNC_DIV, 4'd7, 8'h03, 8'h22});
        cdb_valid = 1'b1; cdb_rob = 3'd6; cdb_data = 16'hFF22;
        issue(FUNC_DIV, 4'd7, 3'd5, 1'b0, 3'd0, 8'h03, 1'b1, 3'd6, 8'h55);
        cdb_valid = 1'b0;
        tick();
        n_checks++;
        if ({st, rs2_data} !== {5'b1_1_1_01, 8'h22})
            $display("FAIL t3_bypass: got %b/%h, required 11101/22", st, rs2_data);
        else n_pass++;
        complete(3'd0);
    endtask

    task automatic test_full_oldest();
        exp_q.push_back({3'd1, 3'd2, FUNC_MUL, 4'd2, 8'h02, 8'h03});
        issue(FUNC_MUL, 4'd1, 3'd1, 1'b1, 3'd5, 8'h00, 1'b0, 3'd0, 8'h01);
        issue(FUNC_MUL, 4'd2, 3'd2, 1'b0, 3'd0, 8'h02, 1'b0, 3'd0, 8'h03);
        issue(FUNC_MUL, 4'd3, 3'd3, 1'b0, 3'd0, 8'h04, 1'b1, 3'd6, 8'h00);
        n_checks++;
        if (st !== 5'b1_1_0_11) $display("FAIL t4_full: got %b, required 11011", st);
        else n_pass++;
        issue(FUNC_DIV, 4'd9, 3'd7, 1'b0, 3'd0, 8'hEE, 1'b0, 3'd0, 8'hEE);
        n_checks++;
        if (st !== 5'b0_1_0_11) $display("FAIL t4_issue_blocked: got %b, required 01011", st);
        else n_pass++;
        broadcast(3'd6, 16'h0066);
        broadcast(3'd5, 16'h0055);
        n_checks++;
        if (st !== 5'b0_1_0_11) $display("FAIL t4_woken_busy: got %b, required 01011", st);
        else n_pass++;
        exp_q.push_back({3'd0, 3'd1, FUNC_MUL, 4'd1, 8'h55, 8'h01});
        exp_q.push_back({3'd2, 3'd3, FUNC_MUL, 4'd3, 8'h04, 8'h66});
        complete(3'd1);
        n_checks++;
        if (st !== 5'b0_0_1_10) $display("FAIL t4_slot_freed: got %b, required 00110", st);
        else n_pass++;
        tick();
        n_checks++;
        if ({st, rs_index} !== {5'b1_1_1_10, 3'd0})
            $display("FAIL t4_oldest_first: got %b/%0d, required 11110/0", st, rs_index);
        else n_pass++;
        complete(3'd0);
        tick();
        n_checks++;
        if ({ex_b, rs_index} !== {1'b1, 3'd2})
            $display("FAIL t4_second: got %b/%0d, required 1/2", ex_b, rs_index);
        else n_pass++;
        complete(3'd2);
        n_checks++;
        if (st !== 5'b0_0_1_00) $display("FAIL t4_drained: got %b, required 00100", st);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_q.push_back({3'd0, 3'd4, FUNC_MUL, 4'd8, 8'h10, 8'h11});
        exp_q.push_back({3'd1, 3'd5, 4'hF, 4'd9, 8'h12, 8'h13});
        issue(FUNC_MUL, 4'd8, 3'd4, 1'b0, 3'd0, 8'h10, 1'b0, 3'd0, 8'h11);
        issue(4'hF, 4'd9, 3'd5, 1'b0, 3'd0, 8'h12, 1'b0, 3'd0, 8'h13);
        n_checks++;
        if ({st, rs_index} !== {5'b1_1_1_10, 3'd0})
            $display("FAIL t5_first: got %b/%0d, required 11110/0", st, rs_index);
        else n_pass++;
        complete(3'd1);
        n_checks++;
        if (st !== 5'b0_1_1_10) $display("FAIL t5_stray_done: got %b, required 01110", st);
        else n_pass++;
        complete(3'd0);
        n_checks++;
        if (st !== 5'b0_0_1_01) $display("FAIL t5_bubble: got %b, required 00101", st);
        else n_pass++;
        tick();
        n_checks++;
        if ({st, rs_index} !== {5'b1_1_1_01, 3'd1})
            $display("FAIL t5_second: got %b/%0d, required 11101/1", st, rs_index);
        else n_pass++;
        complete(3'd1);
    endtask

    task automatic test_flush();
        exp_q.push_back({3'd0, 3'd6, FUNC_DIV, 4'd2, 8'h21, 8'h03});
        issue(FUNC_DIV, 4'd2, 3'd6, 1'b0, 3'd0, 8'h21, 1'b0, 3'd0, 8'h03);
        tick();
        n_checks++;
        if (st !== 5'b1_1_1_01) $display("FAIL t6_inflight: got %b, required 11101", st);
        else n_pass++;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if ({st, rs1_data, rs2_data, rob_ind} !== {5'b0_0_1_00, 19'd0})
            $display("FAIL t6_flush: got %b/%h/%h/%0d, required 00100/00/00/0", st, rs1_data, rs2_data, rob_ind);
        else n_pass++;
        complete(3'd0);
        n_checks++;
        if (st !== 5'b0_0_1_00) $display("FAIL t6_late_done: got %b, required 00100", st);
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if (st !== 5'b0_0_1_00) $display("FAIL t6_quiet: got %b, required 00100", st);
        else n_pass++;
        exp_q.push_back({3'd0, 3'd7, FUNC_MUL, 4'd3, 8'h31, 8'h32});
        issue(FUNC_MUL, 4'd3, 3'd7, 1'b0, 3'd0, 8'h31, 1'b0, 3'd0, 8'h32);
        tick();
        n_checks++;
        if ({st, rs_index} !== {5'b1_1_1_01, 3'd0})
            $display("FAIL t6_reuse: got %b/%0d, required 11101/0", st, rs_index);
        else n_pass++;
        complete(3'd0);
    endtask

    initial begin
        test_reset();
        test_ready_dispatch();
        test_cdb_wakeup();
        test_bypass();
        test_full_oldest();
        test_back_to_back();
        test_flush();
        tick();
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
